// File: rtl/axis2fifo_pack_if.sv
// ---------------------------------------------------------------------------
// axis2fifo_pack_if
//
// Purpose:
//   Bundles the AXI4-Stream sink signals and the FIFO write-side signals
//   of axis2fifo_pack into one interface, so the packer and its environment
//   connect through a single port.
//
// Signal summary:
//   S_AXIS_TREADY   sink ready (packer -> source)
//   S_AXIS_TDATA    beat data, AXIS_DATA_WIDTH bits
//   S_AXIS_TSTRB    byte strobes (not used by the packer)
//   S_AXIS_TLAST    end of line/packet
//   S_AXIS_TVALID   beat valid
//   S_AXIS_USER     start of frame, on the first beat of a frame
//   fwr_rdy         FIFO write side ready
//   fwr_full        FIFO full
//   fwr_cnt         FIFO fill level in words, FAW+1 bits
//   fwr_vld         output word valid
//   fwr_dat         packed output word, AXI4_DATA_WIDTH bits
//   fwr_sof         output word holds the first beat of a frame
//   fwr_last        output word holds a TLAST beat
//   fwr_lanes       number of valid lanes minus 1
//   sync_err        one-cycle pulse when a frame start cuts a partial word
//
// Modports:
//   slave   the packer's view (AXIS sink, FIFO write master)
//   master  the environment's view (AXIS source, FIFO write side)
// ---------------------------------------------------------------------------
interface axis2fifo_pack_if #(
  parameter int FAW             = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128
);

  localparam int RATIO = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int LW    = $clog2(RATIO);

  logic                         S_AXIS_TREADY;
  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB;
  logic                         S_AXIS_TLAST;
  logic                         S_AXIS_TVALID;
  logic                         S_AXIS_USER;

  logic                         fwr_rdy;
  logic                         fwr_full;
  logic [FAW:0]                 fwr_cnt;
  logic                         fwr_vld;
  logic [AXI4_DATA_WIDTH-1:0]   fwr_dat;
  logic                         fwr_sof;
  logic                         fwr_last;
  logic [LW-1:0]                fwr_lanes;
  logic                         sync_err;

  modport slave (
    output S_AXIS_TREADY,
    input  S_AXIS_TDATA,
    input  S_AXIS_TSTRB,
    input  S_AXIS_TLAST,
    input  S_AXIS_TVALID,
    input  S_AXIS_USER,
    input  fwr_rdy,
    input  fwr_full,
    input  fwr_cnt,
    output fwr_vld,
    output fwr_dat,
    output fwr_sof,
    output fwr_last,
    output fwr_lanes,
    output sync_err
  );

  modport master (
    input  S_AXIS_TREADY,
    output S_AXIS_TDATA,
    output S_AXIS_TSTRB,
    output S_AXIS_TLAST,
    output S_AXIS_TVALID,
    output S_AXIS_USER,
    output fwr_rdy,
    output fwr_full,
    output fwr_cnt,
    input  fwr_vld,
    input  fwr_dat,
    input  fwr_sof,
    input  fwr_last,
    input  fwr_lanes,
    input  sync_err
  );

endinterface

// File: rtl/axis2fifo_pack.sv
// ---------------------------------------------------------------------------
// axis2fifo_pack
//
// Purpose:
//   Packs a narrow AXI4-Stream beat stream into wide FIFO write words for the
//   AXI4 burst writer. Frames are synchronised on S_AXIS_USER: beats before
//   the first start-of-frame are dropped, and a start-of-frame that arrives
//   mid-word discards the partial word and pulses sync_err. The finished word
//   sits in an output register that is held until the FIFO takes it. Input
//   is throttled when the FIFO fill level approaches full.
//
// Ports:
//   S_AXIS_ACLK     clock for the whole block
//   S_AXIS_ARESET   synchronous, active-high reset
//   io              axis2fifo_pack_if.slave: AXIS sink + FIFO write side
//
// Parameters:
//   FAW              FIFO address width (depth = 2^FAW words)
//   AXIS_DATA_WIDTH  beat width
//   AXI4_DATA_WIDTH  word width, integer multiple (>= 2) of the beat width
//   FIFO_MARGIN      input stalls when fwr_cnt >= 2^FAW - FIFO_MARGIN
//
// Build option:
//   AXIS2FIFO_TLAST_FLUSH_EN  when defined, a TLAST beat emits the current
//                             word even if only partly filled; unfilled
//                             lanes are zero and fwr_lanes reports the
//                             filled lanes minus 1. When undefined, words
//                             are always full.
//
// Lane order: lane i sits at fwr_dat[AXI4_DATA_WIDTH-1-i*AXIS_DATA_WIDTH -:
// AXIS_DATA_WIDTH], so the first beat of a word lands in the MS lane.
// ---------------------------------------------------------------------------
module axis2fifo_pack #(
  parameter int FAW             = 8,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int FIFO_MARGIN     = 4
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESET,
  axis2fifo_pack_if.slave         io
);

  localparam int RATIO = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int LW    = $clog2(RATIO);

  // Fill level at and above which the input is stalled.
  localparam logic [FAW:0] AFULL_TH = (FAW+1)'((1 << FAW) - FIFO_MARGIN);

  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Frame state and the word being assembled.
  state_t                     state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic [AXI4_DATA_WIDTH-1:0] acc_q, acc_d;
  logic                       acc_sof_q, acc_sof_d;

  // Registered output word and status.
  logic                       vld_q, vld_d;
  logic [AXI4_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                       sof_q, sof_d;
  logic                       last_q, last_d;
  logic [LW-1:0]              lanes_q, lanes_d;
  logic                       sync_err_q, sync_err_d;

  logic                       afull;
  logic                       drain;
  logic                       tready;
  logic                       accept;
  logic                       flush_hit;
  logic [LW-1:0]              beat_lane;
  logic [AXI4_DATA_WIDTH-1:0] packed_word;
  logic                       packed_sof;
  logic                       emit;

  // Byte strobes carry no meaning here; every byte of a beat is kept.
  logic unused_tstrb;
  assign unused_tstrb = ^io.S_AXIS_TSTRB;

  // Handshake terms. The output register can take a new word when it is
  // empty or when its current word leaves on this very edge, which is what
  // allows one beat per cycle with no bubble between words.
  assign afull  = (io.fwr_cnt >= AFULL_TH) | io.fwr_full;
  assign drain  = vld_q & io.fwr_rdy & ~io.fwr_full;
  assign tready = ~afull & (~vld_q | drain);
  assign accept = io.S_AXIS_TVALID & tready;

`ifdef AXIS2FIFO_TLAST_FLUSH_EN
  assign flush_hit = io.S_AXIS_TLAST;
`else
  assign flush_hit = 1'b0;
`endif

  // Where the incoming beat lands. A start-of-frame beat always restarts the
  // word at lane 0 on top of an empty accumulator, whatever was pending.
  always_comb begin
    beat_lane   = io.S_AXIS_USER ? '0 : lane_q;
    packed_word = io.S_AXIS_USER ? '0 : acc_q;
    packed_sof  = io.S_AXIS_USER ? 1'b1 : acc_sof_q;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_lane == LW'(i)) begin
        packed_word[AXI4_DATA_WIDTH-1-i*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH] = io.S_AXIS_TDATA;
      end
    end
    emit = (beat_lane == LAST_LANE) | flush_hit;
  end

  // Next-state logic for the frame FSM, the accumulator and the output
  // register. Beats in HUNT without USER are accepted but dropped so the
  // source is never blocked while we wait for a frame start.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    acc_sof_d  = acc_sof_q;
    vld_d      = vld_q & ~drain;
    dat_d      = dat_q;
    sof_d      = sof_q;
    last_d     = last_q;
    lanes_d    = lanes_q;
    sync_err_d = 1'b0;

    if (accept && (state_q == RUN || io.S_AXIS_USER)) begin
      state_d = RUN;

      if (state_q == RUN && io.S_AXIS_USER && lane_q != '0) begin
        sync_err_d = 1'b1;
      end

      if (emit) begin
        vld_d     = 1'b1;
        dat_d     = packed_word;
        sof_d     = packed_sof;
        last_d    = io.S_AXIS_TLAST;
        lanes_d   = beat_lane;
        acc_d     = '0;
        acc_sof_d = 1'b0;
        lane_d    = '0;
      end else begin
        acc_d     = packed_word;
        acc_sof_d = packed_sof;
        lane_d    = beat_lane + LW'(1);
      end
    end
  end

  // State and output registers. Reset drops any partial word and any word
  // still waiting in the output register.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= HUNT;
      lane_q     <= '0;
      acc_q      <= '0;
      acc_sof_q  <= 1'b0;
      vld_q      <= 1'b0;
      dat_q      <= '0;
      sof_q      <= 1'b0;
      last_q     <= 1'b0;
      lanes_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      acc_sof_q  <= acc_sof_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      sof_q      <= sof_d;
      last_q     <= last_d;
      lanes_q    <= lanes_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign io.S_AXIS_TREADY = tready;
  assign io.fwr_vld       = vld_q;
  assign io.fwr_dat       = dat_q;
  assign io.fwr_sof       = sof_q;
  assign io.fwr_last      = last_q;
  assign io.fwr_lanes     = lanes_q;
  assign io.sync_err      = sync_err_q;

endmodule
